// File: rtl/clock_set_ctrl.sv
// Mode/time-set controller for the 24h clock.
// Synchronizes MODE/UP buttons, sequences RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN,
// and produces registered advance/clear pulses, a timebase re-phase pulse and blink masks.
// Optional feature: define CLOCK_SET_AUTOREPEAT_EN to enable 2 Hz auto-repeat of a held UP
// button in SET_HOUR/SET_MIN after HOLD_EDGES rising edges of SIG2HZ.
module clock_set_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_EDGES  = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN1HZ,
    input  logic       SIG2HZ,
    input  logic       BTN_MODE,
    input  logic       BTN_UP,
    output logic       SEC_EN,
    output logic       MIN_INC,
    output logic       HOUR_INC,
    output logic       SEC_CLR,
    output logic       TB_RST,
    output logic [1:0] MODE,
    output logic       BLANK_H,
    output logic       BLANK_M,
    output logic       BLANK_S
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StSetHour = 2'd1,
        StSetMin  = 2'd2,
        StSetSec  = 2'd3
    } state_e;

    // Elaboration-time parameter sanity checks
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (HOLD_EDGES < 1) begin : g_bad_hold
        $error("HOLD_EDGES must be at least 1");
    end

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] mode_sync_q, mode_sync_d;
    logic [SYNC_STAGES-1:0] up_sync_q, up_sync_d;
    logic mode_prev_q, mode_prev_d;
    logic up_prev_q, up_prev_d;
    logic mode_press_q, mode_press_d;
    logic up_press_q, up_press_d;

    logic sec_en_q, sec_en_d;
    logic min_inc_q, min_inc_d;
    logic hour_inc_q, hour_inc_d;
    logic sec_clr_q, sec_clr_d;
    logic tb_rst_q, tb_rst_d;
    logic blank_h_q, blank_h_d;
    logic blank_m_q, blank_m_d;
    logic blank_s_q, blank_s_d;

    logic up_act;
    logic rep_hit;

    // Button synchronizers and registered rising-edge detectors
    always_comb begin
        mode_sync_d  = {mode_sync_q[SYNC_STAGES-2:0], BTN_MODE};
        up_sync_d    = {up_sync_q[SYNC_STAGES-2:0], BTN_UP};
        mode_prev_d  = mode_sync_q[SYNC_STAGES-1];
        up_prev_d    = up_sync_q[SYNC_STAGES-1];
        mode_press_d = mode_sync_q[SYNC_STAGES-1] & ~mode_prev_q;
        up_press_d   = up_sync_q[SYNC_STAGES-1] & ~up_prev_q;
    end

    // Next state: each MODE press steps to the following mode
    always_comb begin
        state_d = state_q;
        if (mode_press_q) begin
            unique case (state_q)
                StRun:     state_d = StSetHour;
                StSetHour: state_d = StSetMin;
                StSetMin:  state_d = StSetSec;
                StSetSec:  state_d = StRun;
            endcase
        end
    end

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int unsigned CntW = (HOLD_EDGES < 1) ? 1 : $clog2(HOLD_EDGES + 1);

    logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
    logic            sig_prev_q, sig_prev_d;
    logic            sig_rise;

    // Hold counter: counts SIG2HZ rising edges while UP stays held in an hour/min set state
    always_comb begin
        sig_prev_d = SIG2HZ;
        sig_rise   = SIG2HZ & ~sig_prev_q;
        hold_cnt_d = hold_cnt_q;
        rep_hit    = 1'b0;
        if (!up_sync_q[SYNC_STAGES-1] || (state_d != state_q) ||
            !((state_q == StSetHour) || (state_q == StSetMin))) begin
            hold_cnt_d = '0;
        end else if (sig_rise) begin
            if (hold_cnt_q >= CntW'(HOLD_EDGES)) begin
                rep_hit = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + CntW'(1);
            end
        end
    end

    // Auto-repeat state registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_cnt_q <= '0;
            sig_prev_q <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            sig_prev_q <= sig_prev_d;
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

    // Output pulses and blink masks; the pre-transition state picks the pulse, MODE wins over UP
    always_comb begin
        up_act     = up_press_q & ~mode_press_q;
        sec_en_d   = EN1HZ & (state_q == StRun);
        hour_inc_d = (state_q == StSetHour) & (up_act | (rep_hit & ~mode_press_q));
        min_inc_d  = (state_q == StSetMin) & (up_act | (rep_hit & ~mode_press_q));
        sec_clr_d  = (state_q == StSetSec) & up_act;
        tb_rst_d   = (state_q == StSetSec) & up_act;
        // Masks follow the next state so they line up with MODE
        blank_h_d  = (state_d == StSetHour) & ~SIG2HZ;
        blank_m_d  = (state_d == StSetMin) & ~SIG2HZ;
        blank_s_d  = (state_d == StSetSec) & ~SIG2HZ;
    end

    // State, synchronizer and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StRun;
            mode_sync_q  <= '0;
            up_sync_q    <= '0;
            mode_prev_q  <= 1'b0;
            up_prev_q    <= 1'b0;
            mode_press_q <= 1'b0;
            up_press_q   <= 1'b0;
            sec_en_q     <= 1'b0;
            min_inc_q    <= 1'b0;
            hour_inc_q   <= 1'b0;
            sec_clr_q    <= 1'b0;
            tb_rst_q     <= 1'b0;
            blank_h_q    <= 1'b0;
            blank_m_q    <= 1'b0;
            blank_s_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_sync_q  <= mode_sync_d;
            up_sync_q    <= up_sync_d;
            mode_prev_q  <= mode_prev_d;
            up_prev_q    <= up_prev_d;
            mode_press_q <= mode_press_d;
            up_press_q   <= up_press_d;
            sec_en_q     <= sec_en_d;
            min_inc_q    <= min_inc_d;
            hour_inc_q   <= hour_inc_d;
            sec_clr_q    <= sec_clr_d;
            tb_rst_q     <= tb_rst_d;
            blank_h_q    <= blank_h_d;
            blank_m_q    <= blank_m_d;
            blank_s_q    <= blank_s_d;
        end
    end

    assign SEC_EN   = sec_en_q;
    assign MIN_INC  = min_inc_q;
    assign HOUR_INC = hour_inc_q;
    assign SEC_CLR  = sec_clr_q;
    assign TB_RST   = tb_rst_q;
    assign MODE     = state_q;
    assign BLANK_H  = blank_h_q;
    assign BLANK_M  = blank_m_q;
    assign BLANK_S  = blank_s_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: table-driven segments, directed corner cases,
// and randomized stimulus against a cycle-level reference model.
module tb_clock_set_ctrl;

    localparam int S = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN1HZ = 1'b0;
    logic       SIG2HZ = 1'b0;
    logic       BTN_MODE = 1'b0;
    logic       BTN_UP = 1'b0;
    logic       SEC_EN, MIN_INC, HOUR_INC, SEC_CLR, TB_RST;
    logic [1:0] MODE;
    logic       BLANK_H, BLANK_M, BLANK_S;

    clock_set_ctrl #(
        .SYNC_STAGES(S),
        .HOLD_EDGES (2)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN1HZ   (EN1HZ),
        .SIG2HZ  (SIG2HZ),
        .BTN_MODE(BTN_MODE),
        .BTN_UP  (BTN_UP),
        .SEC_EN  (SEC_EN),
        .MIN_INC (MIN_INC),
        .HOUR_INC(HOUR_INC),
        .SEC_CLR (SEC_CLR),
        .TB_RST  (TB_RST),
        .MODE    (MODE),
        .BLANK_H (BLANK_H),
        .BLANK_M (BLANK_M),
        .BLANK_S (BLANK_S)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass = 0;

    int c_sec = 0, c_min = 0, c_hour = 0, c_clr = 0, c_tbr = 0;
    int onehot_viol = 0, pair_viol = 0;

    // Pulse counters and invariants, sampled on the falling edge
    always @(negedge CLK) begin
        c_sec  += int'(SEC_EN);
        c_min  += int'(MIN_INC);
        c_hour += int'(HOUR_INC);
        c_clr  += int'(SEC_CLR);
        c_tbr  += int'(TB_RST);
        if (int'(SEC_EN) + int'(MIN_INC) + int'(HOUR_INC) + int'(SEC_CLR) > 1) onehot_viol++;
        if (SEC_CLR != TB_RST) pair_viol++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic press_mode();
        BTN_MODE = 1'b1;
        tick(3);
        BTN_MODE = 1'b0;
        tick(5);
    endtask

    task automatic press_up();
        BTN_UP = 1'b1;
        tick(3);
        BTN_UP = 1'b0;
        tick(5);
    endtask

    task automatic pulse_en();
        EN1HZ = 1'b1;
        tick(1);
        EN1HZ = 1'b0;
        tick(3);
    endtask

    typedef struct {
        int modes; int ups; int ens; bit sig;
        int e_mode; int e_sec; int e_hour; int e_min; int e_clr;
        bit e_bh; bit e_bm; bit e_bs;
    } row_t;

    row_t rows[10];

    // Reference model state for the random phase
    int m_mode;
    bit hm[$];
    bit hu[$];

    initial begin
        int s0, h0, m0, cl0, tb0, k;
        bit pm, pu, upe;
        int nm;
        logic [9:0] expv, actv;
        int bm_cnt, bu_cnt, sig_cnt;

        // modes ups ens sig | mode sec hour min clr | bh bm bs
        rows[0] = '{0, 0, 3, 1'b1, 0, 3, 0, 0, 0, 1'b0, 1'b0, 1'b0};
        rows[1] = '{1, 5, 2, 1'b0, 1, 0, 5, 0, 0, 1'b1, 1'b0, 1'b0};
        rows[2] = '{1, 3, 2, 1'b0, 2, 0, 0, 3, 0, 1'b0, 1'b1, 1'b0};
        rows[3] = '{1, 2, 1, 1'b0, 3, 0, 0, 0, 2, 1'b0, 1'b0, 1'b1};
        rows[4] = '{1, 0, 2, 1'b0, 0, 2, 0, 0, 0, 1'b0, 1'b0, 1'b0};
        rows[5] = '{0, 3, 1, 1'b0, 0, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0};
        rows[6] = '{1, 0, 0, 1'b1, 1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
        rows[7] = '{1, 0, 0, 1'b1, 2, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
        rows[8] = '{0, 2, 0, 1'b0, 2, 0, 0, 2, 0, 1'b0, 1'b1, 1'b0};
        rows[9] = '{2, 0, 1, 1'b0, 0, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0};

        // Reset state
        tick(2);
        chk("rst_mode", int'(MODE), 0);
        chk("rst_pulses", int'({SEC_EN, MIN_INC, HOUR_INC, SEC_CLR, TB_RST}), 0);
        chk("rst_blank", int'({BLANK_H, BLANK_M, BLANK_S}), 0);
        RST = 1'b0;
        tick(2);

        // Table-driven segments
        for (int r = 0; r < 10; r++) begin
            s0 = c_sec; h0 = c_hour; m0 = c_min; cl0 = c_clr; tb0 = c_tbr;
            SIG2HZ = rows[r].sig;
            for (int i = 0; i < rows[r].modes; i++) press_mode();
            for (int i = 0; i < rows[r].ups; i++) press_up();
            for (int i = 0; i < rows[r].ens; i++) pulse_en();
            tick(6);
            chk($sformatf("row%0d_mode", r), int'(MODE), rows[r].e_mode);
            chk($sformatf("row%0d_sec_en", r), c_sec - s0, rows[r].e_sec);
            chk($sformatf("row%0d_hour_inc", r), c_hour - h0, rows[r].e_hour);
            chk($sformatf("row%0d_min_inc", r), c_min - m0, rows[r].e_min);
            chk($sformatf("row%0d_sec_clr", r), c_clr - cl0, rows[r].e_clr);
            chk($sformatf("row%0d_tb_rst", r), c_tbr - tb0, rows[r].e_clr);
            chk($sformatf("row%0d_blank", r), int'({BLANK_H, BLANK_M, BLANK_S}),
                int'({rows[r].e_bh, rows[r].e_bm, rows[r].e_bs}));
        end

        // EN1HZ to SEC_EN latency: exactly one cycle, one cycle wide
        EN1HZ = 1'b1;
        chk("sec_en_before", int'(SEC_EN), 0);
        tick(1);
        EN1HZ = 1'b0;
        chk("sec_en_after1", int'(SEC_EN), 1);
        tick(1);
        chk("sec_en_width", int'(SEC_EN), 0);
        tick(3);

        // EN1HZ coincident with MODE press in RUN still gives SEC_EN
        BTN_MODE = 1'b1;
        tick(3);
        EN1HZ = 1'b1;
        tick(1);
        EN1HZ = 1'b0;
        chk("run_coinc_sec_en", int'(SEC_EN), 1);
        chk("run_coinc_mode", int'(MODE), 1);
        BTN_MODE = 1'b0;
        tick(5);

        // EN1HZ coincident with MODE press in SET_SEC gives no SEC_EN
        press_mode();
        press_mode();
        s0 = c_sec;
        BTN_MODE = 1'b1;
        tick(3);
        EN1HZ = 1'b1;
        tick(1);
        EN1HZ = 1'b0;
        chk("setsec_coinc_mode", int'(MODE), 0);
        BTN_MODE = 1'b0;
        tick(5);
        chk("setsec_coinc_sec_en", c_sec - s0, 0);

        // Button-to-pulse latency SYNC_STAGES+2 in SET_HOUR
        press_mode();
        BTN_UP = 1'b1;
        k = 0;
        while (k < 10 && !HOUR_INC) begin
            tick(1);
            k++;
        end
        chk("up_latency", k, S + 2);
        BTN_UP = 1'b0;
        tick(6);

        // Simultaneous MODE and UP in SET_MIN: MODE wins, UP dropped
        press_mode();
        m0 = c_min; cl0 = c_clr;
        BTN_MODE = 1'b1;
        BTN_UP = 1'b1;
        tick(3);
        BTN_MODE = 1'b0;
        BTN_UP = 1'b0;
        tick(6);
        chk("mode_up_mode", int'(MODE), 3);
        chk("mode_up_min_inc", c_min - m0, 0);
        chk("mode_up_sec_clr", c_clr - cl0, 0);
        press_mode();
        press_mode();
        press_mode();

        // Held UP across six SIG2HZ rising edges in SET_MIN
        m0 = c_min;
        SIG2HZ = 1'b1;
        BTN_UP = 1'b1;
        tick(4);
        repeat (6) begin
            SIG2HZ = 1'b0;
            tick(8);
            SIG2HZ = 1'b1;
            tick(8);
        end
        BTN_UP = 1'b0;
        SIG2HZ = 1'b0;
        tick(6);
`ifdef CLOCK_SET_AUTOREPEAT_EN
        chk("hold_min_inc", c_min - m0, 5);
`else
        chk("hold_min_inc", c_min - m0, 1);
`endif
        chk("hold_mode", int'(MODE), 2);

        // Reset in SET_MIN with an UP press in flight
        m0 = c_min;
        BTN_UP = 1'b1;
        tick(3);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        chk("rst_mid_mode", int'(MODE), 0);
        chk("rst_mid_min_now", int'(MIN_INC), 0);
        tick(10);
        BTN_UP = 1'b0;
        tick(6);
        chk("rst_mid_min_inc", c_min - m0, 0);
        chk("rst_mid_mode_after", int'(MODE), 0);

        // Randomized phase against the reference model
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        m_mode = 0;
        hm = {};
        hu = {};
        for (int i = 0; i < S + 2; i++) begin
            hm.push_back(1'b0);
            hu.push_back(1'b0);
        end
        bm_cnt = 0; bu_cnt = 0; sig_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            EN1HZ = ($urandom_range(9) == 0);
            if (++sig_cnt == 16) begin
                sig_cnt = 0;
                SIG2HZ = ~SIG2HZ;
            end
            if (bm_cnt > 0) bm_cnt--;
            else if (BTN_MODE) begin
                BTN_MODE = 1'b0;
                bm_cnt = $urandom_range(2, 10);
            end else if ($urandom_range(7) == 0) begin
                BTN_MODE = 1'b1;
                bm_cnt = $urandom_range(0, 3);
            end
            if (bu_cnt > 0) bu_cnt--;
            else if (BTN_UP) begin
                BTN_UP = 1'b0;
                bu_cnt = $urandom_range(2, 10);
            end else if ($urandom_range(5) == 0) begin
                BTN_UP = 1'b1;
                bu_cnt = $urandom_range(0, 3);
            end

            // A press is a 0->1 step in the sampled button, seen S+1 edges later
            pm = hm[hm.size() - 1 - S] & ~hm[hm.size() - 2 - S];
            pu = hu[hu.size() - 1 - S] & ~hu[hu.size() - 2 - S];
            nm = pm ? (m_mode + 1) % 4 : m_mode;
            upe = pu && !pm;
            expv = {EN1HZ && m_mode == 0, upe && m_mode == 2, upe && m_mode == 1,
                    upe && m_mode == 3, upe && m_mode == 3, 2'(nm),
                    nm == 1 && !SIG2HZ, nm == 2 && !SIG2HZ, nm == 3 && !SIG2HZ};

            tick(1);
            actv = {SEC_EN, MIN_INC, HOUR_INC, SEC_CLR, TB_RST, MODE, BLANK_H, BLANK_M, BLANK_S};
            chk($sformatf("rand_c%0d", cyc), int'(actv), int'(expv));
            hm.push_back(BTN_MODE);
            hu.push_back(BTN_UP);
            void'(hm.pop_front());
            void'(hu.pop_front());
            m_mode = nm;
        end

        chk("onehot_pulses", onehot_viol, 0);
        chk("clr_tbrst_pair", pair_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
